// File: rtl/motion_pkg.sv
// Shared motion types: segment layout and sequencer state encoding.
// Used by seg_queue and seg_fifo.
package motion_pkg;

  localparam int SEG_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seg_state_e;

  // dt in the upper half, steps in the lower half
  typedef struct packed {
    logic [SEG_W-1:0] dt;
    logic [SEG_W-1:0] steps;
  } seg_t;

  // zero dt or zero steps would wrap the step generator's limit-1
  function automatic logic seg_ok(seg_t s);
    return (s.dt != '0) && (s.steps != '0);
  endfunction

endpackage

// File: rtl/seg_fifo.sv
// Show-ahead segment FIFO, DEPTH x 64, with flush.
// Pointers carry an extra wrap bit to tell full from empty.
module seg_fifo
  import motion_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  seg_t                     din,
  output seg_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  seg_t        mem_q [DEPTH];
  seg_t        mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // next pointers and storage; flush discards everything incl. a same-cycle push
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  // pointer and storage registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/seg_queue.sv
// Segment sequencer feeding acc_step_gen: buffers, issues and chains segments.
// Optional step counter under SEG_QUEUE_TOTAL_STEPS_EN.
module seg_queue
  import motion_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [SEG_W-1:0]       wr_dt,
  input  logic [SEG_W-1:0]       wr_steps,
  input  logic                   enable,
  input  logic                   abort,
  input  logic                   clr,
  input  logic                   done,
  input  logic                   stopped,
  input  logic                   step_stb,
  output logic [SEG_W-1:0]       dt_val,
  output logic [SEG_W-1:0]       steps_val,
  output logic                   load,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   underrun,
  output logic                   overflow,
  output logic                   reject,
  output logic [SEG_W-1:0]       total_steps
);

  seg_state_e state_q, state_d;
  logic       underrun_q, underrun_d;
  logic       overflow_q, overflow_d;
  logic       reject_q, reject_d;
  logic       flush;
  logic       push_ok;
  logic       underrun_set;
  seg_t       din;
  seg_t       head;

  assign din     = '{dt: wr_dt, steps: wr_steps};
  assign push_ok = wr_en && !full && seg_ok(din);

  seg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (load),
    .flush (flush),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign dt_val    = head.dt;
  assign steps_val = head.steps;
  assign busy      = (state_q != IDLE);
  assign underrun  = underrun_q;
  assign overflow  = overflow_q;
  assign reject    = reject_q;

  // issue/chain/abort control; load never fires while empty
  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    flush        = 1'b0;
    underrun_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (abort) begin
          flush = 1'b1;
        end else if (enable && !empty && stopped) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = DRAIN;
        end else if (done && enable && !empty) begin
          load = 1'b1;
        end else if (done) begin
          state_d      = IDLE;
          underrun_set = enable && empty;
        end
      end
      DRAIN: begin
        flush = abort;
        if (done || stopped) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sticky flags: a set in the same cycle as clr wins
  always_comb begin
    underrun_d = (underrun_q && !clr) || underrun_set;
    overflow_d = (overflow_q && !clr) || (wr_en && full);
    reject_d   = (reject_q && !clr) || (wr_en && !seg_ok(din));
  end

  // state and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      reject_q   <= reject_d;
    end
  end

`ifdef SEG_QUEUE_TOTAL_STEPS_EN
  logic [SEG_W-1:0] total_q, total_d;
  logic [SEG_W-1:0] total_inc;

  assign total_inc   = {{(SEG_W-1){1'b0}}, step_stb && busy};
  assign total_steps = total_q;

  // running step count, wraps naturally
  always_comb begin
    total_d = (clr ? '0 : total_q) + total_inc;
  end

  // step counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end
`else
  logic unused_step_stb;
  assign unused_step_stb = step_stb;
  assign total_steps     = '0;
`endif

endmodule

// File: tb/tb_seg_queue.sv
// Directed bench for seg_queue with a small behavioural acc_step_gen.
// Scoreboard holds the segments expected at each load.
module tb_seg_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] wr_dt = '0;
  logic [31:0] wr_steps = '0;
  logic        enable = 1'b0;
  logic        abort = 1'b0;
  logic        clr = 1'b0;
  logic        done;
  logic        stopped;
  logic        step_stb;
  logic [31:0] dt_val;
  logic [31:0] steps_val;
  logic        load;
  logic        full;
  logic        empty;
  logic [4:0]  count;
  logic        busy;
  logic        underrun;
  logic        overflow;
  logic        reject;
  logic [31:0] total_steps;

  always #5 clk = ~clk;

  seg_queue #(.DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_dt       (wr_dt),
    .wr_steps    (wr_steps),
    .enable      (enable),
    .abort       (abort),
    .clr         (clr),
    .done        (done),
    .stopped     (stopped),
    .step_stb    (step_stb),
    .dt_val      (dt_val),
    .steps_val   (steps_val),
    .load        (load),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .busy        (busy),
    .underrun    (underrun),
    .overflow    (overflow),
    .reject      (reject),
    .total_steps (total_steps)
  );

  // step generator model: dt clocks per step, done in the last clock
  logic        g_run;
  logic [31:0] g_dt;
  logic [31:0] g_cnt;
  logic [31:0] g_rem;

  assign step_stb = g_run && (g_cnt == g_dt - 32'd1);
  assign done     = step_stb && (g_rem == 32'd1);
  assign stopped  = !g_run;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      g_run <= 1'b0;
      g_dt  <= '0;
      g_cnt <= '0;
      g_rem <= '0;
    end else if (load) begin
      g_run <= 1'b1;
      g_dt  <= dt_val;
      g_rem <= steps_val;
      g_cnt <= '0;
    end else if (step_stb) begin
      g_cnt <= '0;
      g_rem <= g_rem - 32'd1;
      if (done) g_run <= 1'b0;
    end else if (g_run) begin
      g_cnt <= g_cnt + 32'd1;
    end
  end

  int          total = 0;
  int          bad = 0;
  int          cnum = 0;
  int          busy_cyc = 0;
  int          loads = 0;
  int          ldn = 0;
  int          last = 0;
  bit          trk = 0;
  bit          trk_first = 0;
  int          gaps[$];
  logic [63:0] sb[$];
  int          exp_gaps[7] = '{2, 2, 3, 1, 1, 1, 1};
  int          l0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sample mid-cycle, then step past the next rising edge
  task automatic cyc();
    logic [63:0] e;
    @(negedge clk);
    cnum++;
    if (busy) busy_cyc++;
    if (trk && step_stb) begin
      gaps.push_back(cnum - last);
      last = cnum;
    end
    if (load) begin
      loads++;
      if (done) ldn++;
      if (trk_first) begin
        last = cnum;
        trk_first = 0;
      end
      chk("load_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("load_seg", {dt_val, steps_val}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] dt, input logic [31:0] st);
    wr_en    = 1'b1;
    wr_dt    = dt;
    wr_steps = st;
    cyc();
    wr_en    = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  initial begin
    // reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_load", 64'(load), 64'd0);
    chk("rst_flags", {61'd0, underrun, overflow, reject}, 64'd0);
    chk("rst_total", 64'(total_steps), 64'd0);
    chk("rst_head", {dt_val, steps_val}, 64'd0);
    reset = 1'b0;
    cyc();

    // single segment
    sb.push_back({32'd4, 32'd3});
    push(32'd4, 32'd3);
    busy_cyc = 0;
    loads = 0;
    enable = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    chk("t1_loads", 64'(loads), 64'd1);
    chk("t1_busy_cyc", 64'(busy_cyc), 64'd12);
    chk("t1_underrun", 64'(underrun), 64'd1);
    chk("t1_empty", 64'(empty), 64'd1);

    // chaining
    enable = 1'b0;
    pulse_clr();
    chk("t2_clr", 64'(underrun), 64'd0);
    sb.push_back({32'd2, 32'd2});
    push(32'd2, 32'd2);
    sb.push_back({32'd3, 32'd1});
    push(32'd3, 32'd1);
    sb.push_back({32'd1, 32'd4});
    push(32'd1, 32'd4);
    chk("t2_count", 64'(count), 64'd3);
    loads = 0;
    ldn = 0;
    trk = 1;
    trk_first = 1;
    enable = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    trk = 0;
    chk("t2_loads", 64'(loads), 64'd3);
    chk("t2_chained", 64'(ldn), 64'd2);
    chk("t2_ngaps", 64'(gaps.size()), 64'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < gaps.size()) chk("t2_gap", 64'(gaps[i]), 64'(exp_gaps[i]));
    end
`ifdef SEG_QUEUE_TOTAL_STEPS_EN
    chk("t2_total", 64'(total_steps), 64'd7);
`else
    chk("t2_total", 64'(total_steps), 64'd0);
`endif
    chk("t2_underrun", 64'(underrun), 64'd1);

    // fill beyond capacity
    enable = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb.push_back({32'(i + 1), 32'd1});
      push(32'(i + 1), 32'd1);
    end
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_count", 64'(count), 64'd16);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_head", {dt_val, steps_val}, {32'd1, 32'd1});
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    sb.delete();
    chk("t3_flush", 64'(count), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);
    pulse_clr();
    chk("t3_clr", 64'(overflow), 64'd0);

    // rejects
    push(32'd0, 32'd5);
    push(32'd5, 32'd0);
    chk("t4_reject", 64'(reject), 64'd1);
    chk("t4_count", 64'(count), 64'd0);
    pulse_clr();
    chk("t4_clr", 64'(reject), 64'd0);

    // abort during RUN
    for (int i = 0; i < 3; i++) begin
      sb.push_back({32'd2, 32'd3});
      push(32'd2, 32'd3);
    end
    loads = 0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("t5_run", 64'(busy), 64'd1);
    chk("t5_loads_pre", 64'(loads), 64'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    sb.delete();
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_drain", 64'(busy), 64'd1);
    for (int i = 0; i < 15; i++) cyc();
    chk("t5_idle", 64'(busy), 64'd0);
    chk("t5_loads", 64'(loads), 64'd1);
    chk("t5_underrun", 64'(underrun), 64'd0);
    chk("t5_head", {dt_val, steps_val}, 64'd0);

    // async reset mid-segment
    push(32'd0, 32'd0);
    sb.push_back({32'd4, 32'd3});
    push(32'd4, 32'd3);
    sb.push_back({32'd4, 32'd3});
    push(32'd4, 32'd3);
    for (int i = 0; i < 3; i++) cyc();
    chk("t6_pre_busy", 64'(busy), 64'd1);
    chk("t6_pre_reject", 64'(reject), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_load", 64'(load), 64'd0);
    chk("t6_flags", {61'd0, underrun, overflow, reject}, 64'd0);
    chk("t6_total", 64'(total_steps), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    l0 = loads;
    for (int i = 0; i < 4; i++) cyc();
    chk("t6_quiet", 64'(loads - l0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
